sram_axi_bridge: RTL and testbench

Converts the CPU core's two sram-like ports (instruction and data) into a single AXI3 master. Sits directly downstream of the CPU top, consuming its inst/data memory requests, and replaces direct SRAM attachment once the core moves to a shared AXI memory system. It arbitrates reads between the two ports, issues single-beat transactions, and routes responses back by ID.

---
 rtl/bridge_pkg.sv | 22 ++
 rtl/axi_wr_channel.sv | 125 ++++++++++++
 rtl/sram_axi_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the sram-like to AXI3 bridge: FSM state
// encodings, AXI transaction IDs and fixed burst type.
package bridge_pkg;

  // Read FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;

  // Write FSM states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // AXI IDs used to route responses back to the issuing port
  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  // All transactions are single-beat INCR
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_wr_channel.sv
// Write side of the bridge: owns the write FSM and the AW/W/B handshakes.
// AW and W are launched together and each drops on its own ready; the
// response phase starts only after both have been accepted.
module axi_wr_channel
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [1:0]          size_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                idle_o,
  output logic                done_o,
  output logic [3:0]          awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic [1:0]          awlock_o,
  output logic [3:0]          awcache_o,
  output logic [2:0]          awprot_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [3:0]          wid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  logic [1:0]          wrState_q, wrState_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [2:0]          awsize_q, awsize_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awPend_q, awPend_d;
  logic                wPend_q, wPend_d;

  // Next-state logic: capture the request, retire AW and W independently, wait for B
  always_comb begin
    wrState_d = wrState_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    awPend_d  = awPend_q;
    wPend_d   = wPend_q;
    case (wrState_q)
      W_IDLE: begin
        if (start_i) begin
          wrState_d = W_SEND;
          awaddr_d  = addr_i;
          awsize_d  = {1'b0, size_i};
          wstrb_d   = wstrb_i;
          wdata_d   = wdata_i;
          awPend_d  = 1'b1;
          wPend_d   = 1'b1;
        end
      end
      W_SEND: begin
        awPend_d = awPend_q && !awready_i;
        wPend_d  = wPend_q && !wready_i;
        if (!awPend_d && !wPend_d) begin
          wrState_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_i) begin
          wrState_d = W_IDLE;
        end
      end
      default: wrState_d = W_IDLE;
    endcase
  end

  // State and registered AW/W fields; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrState_q <= W_IDLE;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      awPend_q  <= 1'b0;
      wPend_q   <= 1'b0;
    end else begin
      wrState_q <= wrState_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      awPend_q  <= awPend_d;
      wPend_q   <= wPend_d;
    end
  end

  assign idle_o    = (wrState_q == W_IDLE);
  assign bready_o  = (wrState_q == W_RESP);
  assign done_o    = bready_o && bvalid_i;

  assign awid_o    = DATA_ID;
  assign awaddr_o  = awaddr_q;
  assign awlen_o   = 8'd0;
  assign awsize_o  = awsize_q;
  assign awburst_o = BURST_INCR;
  assign awlock_o  = 2'b00;
  assign awcache_o = 4'b0000;
  assign awprot_o  = 3'b000;
  assign awvalid_o = awPend_q;

  assign wid_o     = DATA_ID;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = wPend_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's inst/data sram-like ports onto one AXI3 master.
// Reads from both ports share one read FSM (data wins ties); data writes
// go through axi_wr_channel concurrently. Responses are routed by rid.
// Optional macro BRIDGE_RAW_CHECK_EN: hold reads that hit the word of a
// pending write until that write has completed.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req_i,
  input  logic                inst_wr_i,
  input  logic [1:0]          inst_size_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  input  logic [DATA_W/8-1:0] inst_wstrb_i,
  input  logic [DATA_W-1:0]   inst_wdata_i,
  output logic                inst_addr_ok_o,
  output logic                inst_data_ok_o,
  output logic [DATA_W-1:0]   inst_rdata_o,
  input  logic                data_req_i,
  input  logic                data_wr_i,
  input  logic [1:0]          data_size_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W/8-1:0] data_wstrb_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_addr_ok_o,
  output logic                data_data_ok_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic [3:0]          arid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [7:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic [1:0]          arlock_o,
  output logic [3:0]          arcache_o,
  output logic [2:0]          arprot_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [3:0]          rid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  output logic [3:0]          awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic [1:0]          awlock_o,
  output logic [3:0]          awcache_o,
  output logic [2:0]          awprot_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [3:0]          wid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [3:0]          bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  logic [1:0]        rdState_q, rdState_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [3:0]        arid_q, arid_d;
  logic [2:0]        arsize_q, arsize_d;

  logic rdIdle, dataRdBusy, dataBusy;
  logic wrIdle, wrDone;
  logic instHold, dataHold;
  logic instRdAccept, dataRdAccept, dataWrAccept;
  logic rdDone;
  logic unusedInputs;

  // Write ports of inst, response codes and bid carry nothing this bridge uses
  assign unusedInputs = ^{inst_wr_i, inst_wstrb_i, inst_wdata_i, rresp_i, rlast_i, bid_i, bresp_i};

  assign rdIdle     = (rdState_q == R_IDLE);
  assign dataRdBusy = !rdIdle && (arid_q == DATA_ID);
  assign dataBusy   = dataRdBusy || !wrIdle;

`ifdef BRIDGE_RAW_CHECK_EN
  assign instHold = !wrIdle && (inst_addr_i[ADDR_W-1:2] == awaddr_o[ADDR_W-1:2]);
  assign dataHold = !wrIdle && (data_addr_i[ADDR_W-1:2] == awaddr_o[ADDR_W-1:2]);
`else
  assign instHold = 1'b0;
  assign dataHold = 1'b0;
`endif

  // Arbitration: one outstanding per port, data read beats inst read, writes run beside reads
  always_comb begin
    dataRdAccept = resetn && data_req_i && !data_wr_i && rdIdle && !dataBusy && !dataHold;
    dataWrAccept = resetn && data_req_i && data_wr_i && !dataBusy;
    instRdAccept = resetn && inst_req_i && rdIdle && !instHold && !dataRdAccept;
  end

  assign inst_addr_ok_o = instRdAccept;
  assign data_addr_ok_o = dataRdAccept || dataWrAccept;

  // Read FSM next state: latch the winning request, hold AR until ready, then wait for R
  always_comb begin
    rdState_d = rdState_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arsize_d  = arsize_q;
    case (rdState_q)
      R_IDLE: begin
        if (dataRdAccept) begin
          rdState_d = R_AR;
          araddr_d  = data_addr_i;
          arid_d    = DATA_ID;
          arsize_d  = {1'b0, data_size_i};
        end else if (instRdAccept) begin
          rdState_d = R_AR;
          araddr_d  = inst_addr_i;
          arid_d    = INST_ID;
          arsize_d  = {1'b0, inst_size_i};
        end
      end
      R_AR: begin
        if (arready_i) begin
          rdState_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rvalid_i) begin
          rdState_d = R_IDLE;
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  // Read FSM registers; reset drops any read in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdState_q <= R_IDLE;
      araddr_q  <= '0;
      arid_q    <= '0;
      arsize_q  <= '0;
    end else begin
      rdState_q <= rdState_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      arsize_q  <= arsize_d;
    end
  end

  assign arid_o    = arid_q;
  assign araddr_o  = araddr_q;
  assign arlen_o   = 8'd0;
  assign arsize_o  = arsize_q;
  assign arburst_o = BURST_INCR;
  assign arlock_o  = 2'b00;
  assign arcache_o = 4'b0000;
  assign arprot_o  = 3'b000;
  assign arvalid_o = (rdState_q == R_AR);
  assign rready_o  = (rdState_q == R_WAIT);

  assign rdDone         = rready_o && rvalid_i;
  assign inst_data_ok_o = rdDone && (rid_i == INST_ID);
  assign data_data_ok_o = (rdDone && (rid_i == DATA_ID)) || wrDone;
  assign inst_rdata_o   = rdata_i;
  assign data_rdata_o   = rdata_i;

  axi_wr_channel #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) uWrChannel (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (dataWrAccept),
    .addr_i    (data_addr_i),
    .size_i    (data_size_i),
    .wstrb_i   (data_wstrb_i),
    .wdata_i   (data_wdata_i),
    .idle_o    (wrIdle),
    .done_o    (wrDone),
    .awid_o    (awid_o),
    .awaddr_o  (awaddr_o),
    .awlen_o   (awlen_o),
    .awsize_o  (awsize_o),
    .awburst_o (awburst_o),
    .awlock_o  (awlock_o),
    .awcache_o (awcache_o),
    .awprot_o  (awprot_o),
    .awvalid_o (awvalid_o),
    .awready_i (awready_i),
    .wid_o     (wid_o),
    .wdata_o   (wdata_o),
    .wstrb_o   (wstrb_o),
    .wlast_o   (wlast_o),
    .wvalid_o  (wvalid_o),
    .wready_i  (wready_i),
    .bvalid_i  (bvalid_i),
    .bready_o  (bready_o)
  );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge. Inputs change on the falling
// edge and outputs are checked 4 ns later, one ns before the rising edge.
// Honours BRIDGE_RAW_CHECK_EN when it is defined for the whole build.
module tb_sram_axi_bridge;
  import bridge_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instReq, instWr, dataReq, dataWr;
  logic [1:0]  instSize, dataSize;
  logic [31:0] instAddr, dataAddr, instWdata, dataWdata;
  logic [3:0]  instWstrb, dataWstrb;
  logic        instAddrOk, instDataOk, dataAddrOk, dataDataOk;
  logic [31:0] instRdata, dataRdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic        instReq;
    logic        instWr;
    logic [1:0]  instSize;
    logic [31:0] instAddr;
    logic        dataReq;
    logic        dataWr;
    logic [1:0]  dataSize;
    logic [31:0] dataAddr;
    logic [3:0]  dataWstrb;
    logic [31:0] dataWdata;
    logic        arready;
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        awready;
    logic        wready;
    logic        bvalid;
  } stim_t;

  typedef struct packed {
    logic        isData;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  arDelay;
    logic [3:0]  rDelay;
    logic [3:0]  expId;
    logic [2:0]  expArsize;
  } rdVec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [3:0]  awDelay;
    logic [3:0]  wDelay;
    logic [3:0]  bDelay;
    logic [2:0]  expAwsize;
  } wrVec_t;

  rdVec_t rdVecs[4];
  wrVec_t wrVecs[3];

  always #5 clk = ~clk;

  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req_i(instReq), .inst_wr_i(instWr), .inst_size_i(instSize),
    .inst_addr_i(instAddr), .inst_wstrb_i(instWstrb), .inst_wdata_i(instWdata),
    .inst_addr_ok_o(instAddrOk), .inst_data_ok_o(instDataOk), .inst_rdata_o(instRdata),
    .data_req_i(dataReq), .data_wr_i(dataWr), .data_size_i(dataSize),
    .data_addr_i(dataAddr), .data_wstrb_i(dataWstrb), .data_wdata_i(dataWdata),
    .data_addr_ok_o(dataAddrOk), .data_data_ok_o(dataDataOk), .data_rdata_o(dataRdata),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
    .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot),
    .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
    .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
    .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot),
    .awvalid_o(awvalid), .awready_i(awready),
    .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast),
    .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  // Drive one cycle of inputs on the falling edge, then wait to just before the rising edge
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    instReq   = s.instReq;
    instWr    = s.instWr;
    instSize  = s.instSize;
    instAddr  = s.instAddr;
    dataReq   = s.dataReq;
    dataWr    = s.dataWr;
    dataSize  = s.dataSize;
    dataAddr  = s.dataAddr;
    dataWstrb = s.dataWstrb;
    dataWdata = s.dataWdata;
    arready   = s.arready;
    rvalid    = s.rvalid;
    rid       = s.rid;
    rdata     = s.rdata;
    awready   = s.awready;
    wready    = s.wready;
    bvalid    = s.bvalid;
    #4;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 32'(act), 32'(exp));
  endtask

  // Complete a read already sitting in R_AR: AR handshake, then the R beat
  task automatic finishRead(input string tag, input logic [3:0] id, input logic [31:0] rd, input logic isData);
    stim_t s;
    s = '0;
    s.arready = 1'b1;
    applyStimulus(s);
    checkBit({tag, "_arvalid"}, arvalid, 1'b1);
    checkOutput({tag, "_arid"}, 32'(arid), 32'(id));
    s = '0;
    s.rvalid = 1'b1;
    s.rid = id;
    s.rdata = rd;
    applyStimulus(s);
    if (isData) begin
      checkBit({tag, "_data_ok"}, dataDataOk, 1'b1);
      checkOutput({tag, "_rdata"}, dataRdata, rd);
    end else begin
      checkBit({tag, "_data_ok"}, instDataOk, 1'b1);
      checkOutput({tag, "_rdata"}, instRdata, rd);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    logic awPend, wPend;

    rdVecs[0] = '{isData:1'b0, wr:1'b0, size:2'd2, addr:32'h1C00_0000, rdata:32'h0280_0C0C,
                  arDelay:4'd0, rDelay:4'd0, expId:4'd0, expArsize:3'd2};
    rdVecs[1] = '{isData:1'b1, wr:1'b0, size:2'd1, addr:32'h0000_1002, rdata:32'hA5A5_1234,
                  arDelay:4'd2, rDelay:4'd1, expId:4'd1, expArsize:3'd1};
    rdVecs[2] = '{isData:1'b1, wr:1'b0, size:2'd0, addr:32'h8000_0003, rdata:32'hDEAD_BEEF,
                  arDelay:4'd0, rDelay:4'd3, expId:4'd1, expArsize:3'd0};
    rdVecs[3] = '{isData:1'b0, wr:1'b1, size:2'd2, addr:32'hBFC0_0004, rdata:32'h1234_5678,
                  arDelay:4'd1, rDelay:4'd0, expId:4'd0, expArsize:3'd2};

    wrVecs[0] = '{addr:32'h0000_0010, size:2'd0, strb:4'b0010, wdata:32'h0000_AB00,
                  awDelay:4'd3, wDelay:4'd0, bDelay:4'd0, expAwsize:3'd0};
    wrVecs[1] = '{addr:32'h1000_0004, size:2'd2, strb:4'b1111, wdata:32'hCAFE_F00D,
                  awDelay:4'd0, wDelay:4'd2, bDelay:4'd1, expAwsize:3'd2};
    wrVecs[2] = '{addr:32'h0000_0202, size:2'd1, strb:4'b1100, wdata:32'hBEEF_0000,
                  awDelay:4'd1, wDelay:4'd1, bDelay:4'd2, expAwsize:3'd1};

    instWstrb = 4'hF;
    instWdata = 32'h0;
    rresp = 2'b00;
    rlast = 1'b1;
    bid = 4'd1;
    bresp = 2'b00;

    // Reset: requests and AXI handshakes present, but everything stays quiet
    resetn = 1'b0;
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h1C00_0000;
    s.dataReq = 1'b1; s.dataWr = 1'b1; s.dataAddr = 32'h10; s.dataWdata = 32'h1234;
    s.arready = 1'b1; s.rvalid = 1'b1; s.awready = 1'b1; s.wready = 1'b1; s.bvalid = 1'b1;
    applyStimulus(s);
    checkBit("rst_inst_addr_ok", instAddrOk, 1'b0);
    checkBit("rst_data_addr_ok", dataAddrOk, 1'b0);
    checkBit("rst_inst_data_ok", instDataOk, 1'b0);
    checkBit("rst_data_data_ok", dataDataOk, 1'b0);
    checkBit("rst_arvalid", arvalid, 1'b0);
    checkBit("rst_awvalid", awvalid, 1'b0);
    checkBit("rst_wvalid", wvalid, 1'b0);
    checkBit("rst_rready", rready, 1'b0);
    checkBit("rst_bready", bready, 1'b0);
    checkOutput("rst_araddr", araddr, 32'h0);
    checkOutput("rst_wdata", wdata, 32'h0);
    s = '0;
    applyStimulus(s);
    resetn = 1'b1;

    // Single reads from the vector table
    for (int i = 0; i < 4; i++) begin
      rdVec_t v;
      v = rdVecs[i];
      s = '0;
      if (v.isData) begin
        s.dataReq = 1'b1; s.dataSize = v.size; s.dataAddr = v.addr;
      end else begin
        s.instReq = 1'b1; s.instWr = v.wr; s.instSize = v.size; s.instAddr = v.addr;
      end
      applyStimulus(s);
      checkBit($sformatf("rd%0d_addr_ok", i), v.isData ? dataAddrOk : instAddrOk, 1'b1);
      checkBit($sformatf("rd%0d_other_addr_ok", i), v.isData ? instAddrOk : dataAddrOk, 1'b0);
      for (int k = 0; k <= int'(v.arDelay); k++) begin
        s = '0;
        s.arready = (k == int'(v.arDelay));
        applyStimulus(s);
        checkBit($sformatf("rd%0d_arvalid_c%0d", i, k), arvalid, 1'b1);
        if (k == 0) begin
          checkOutput($sformatf("rd%0d_araddr", i), araddr, v.addr);
          checkOutput($sformatf("rd%0d_arid", i), 32'(arid), 32'(v.expId));
          checkOutput($sformatf("rd%0d_arsize", i), 32'(arsize), 32'(v.expArsize));
          checkOutput($sformatf("rd%0d_arlen_burst", i), {22'd0, arlen, arburst}, 32'h0000_0001);
        end
      end
      for (int k = 0; k <= int'(v.rDelay); k++) begin
        s = '0;
        s.rvalid = (k == int'(v.rDelay));
        s.rid = v.expId;
        s.rdata = v.rdata;
        applyStimulus(s);
        checkBit($sformatf("rd%0d_rready_c%0d", i, k), rready, 1'b1);
        checkBit($sformatf("rd%0d_data_ok_c%0d", i, k), v.isData ? dataDataOk : instDataOk,
                 k == int'(v.rDelay));
        checkBit($sformatf("rd%0d_other_data_ok_c%0d", i, k), v.isData ? instDataOk : dataDataOk, 1'b0);
      end
      checkOutput($sformatf("rd%0d_rdata", i), v.isData ? dataRdata : instRdata, v.rdata);
      s = '0;
      applyStimulus(s);
      checkBit($sformatf("rd%0d_idle_arvalid", i), arvalid, 1'b0);
      checkBit($sformatf("rd%0d_idle_rready", i), rready, 1'b0);
    end

    // Single writes from the vector table, AW and W retired independently
    for (int i = 0; i < 3; i++) begin
      wrVec_t w;
      w = wrVecs[i];
      s = '0;
      s.dataReq = 1'b1; s.dataWr = 1'b1; s.dataSize = w.size; s.dataAddr = w.addr;
      s.dataWstrb = w.strb; s.dataWdata = w.wdata;
      applyStimulus(s);
      checkBit($sformatf("wr%0d_addr_ok", i), dataAddrOk, 1'b1);
      awPend = 1'b1;
      wPend = 1'b1;
      for (int cyc = 1; awPend || wPend; cyc++) begin
        s = '0;
        s.awready = (cyc >= 1 + int'(w.awDelay));
        s.wready = (cyc >= 1 + int'(w.wDelay));
        applyStimulus(s);
        checkBit($sformatf("wr%0d_awvalid_c%0d", i, cyc), awvalid, awPend);
        checkBit($sformatf("wr%0d_wvalid_c%0d", i, cyc), wvalid, wPend);
        checkBit($sformatf("wr%0d_bready_c%0d", i, cyc), bready, 1'b0);
        if (cyc == 1) begin
          checkOutput($sformatf("wr%0d_awaddr", i), awaddr, w.addr);
          checkOutput($sformatf("wr%0d_awsize", i), 32'(awsize), 32'(w.expAwsize));
          checkOutput($sformatf("wr%0d_wstrb", i), 32'(wstrb), 32'(w.strb));
          checkOutput($sformatf("wr%0d_wdata", i), wdata, w.wdata);
          checkOutput($sformatf("wr%0d_ids_last", i), {23'd0, awid, wid, wlast}, 32'h0000_0023);
        end
        if (s.awready) awPend = 1'b0;
        if (s.wready) wPend = 1'b0;
      end
      for (int k = 0; k <= int'(w.bDelay); k++) begin
        s = '0;
        s.bvalid = (k == int'(w.bDelay));
        applyStimulus(s);
        checkBit($sformatf("wr%0d_bready_r%0d", i, k), bready, 1'b1);
        checkBit($sformatf("wr%0d_data_ok_r%0d", i, k), dataDataOk, k == int'(w.bDelay));
      end
      s = '0;
      applyStimulus(s);
      checkBit($sformatf("wr%0d_idle_bready", i), bready, 1'b0);
    end

    // Both ports read in the same cycle: data first (arid 1), inst afterwards (arid 0)
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h1C00_0100; s.instSize = 2'd2;
    s.dataReq = 1'b1; s.dataAddr = 32'h0000_2000; s.dataSize = 2'd2;
    applyStimulus(s);
    checkBit("arb_data_addr_ok", dataAddrOk, 1'b1);
    checkBit("arb_inst_addr_ok_c0", instAddrOk, 1'b0);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h1C00_0100; s.instSize = 2'd2; s.arready = 1'b1;
    applyStimulus(s);
    checkOutput("arb_first_arid", 32'(arid), 32'd1);
    checkOutput("arb_first_araddr", araddr, 32'h0000_2000);
    checkBit("arb_inst_addr_ok_c1", instAddrOk, 1'b0);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h1C00_0100; s.instSize = 2'd2;
    s.rvalid = 1'b1; s.rid = 4'd1; s.rdata = 32'h1111_2222;
    applyStimulus(s);
    checkBit("arb_data_data_ok", dataDataOk, 1'b1);
    checkOutput("arb_data_rdata", dataRdata, 32'h1111_2222);
    checkBit("arb_inst_data_ok_c2", instDataOk, 1'b0);
    checkBit("arb_inst_addr_ok_c2", instAddrOk, 1'b0);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h1C00_0100; s.instSize = 2'd2;
    applyStimulus(s);
    checkBit("arb_inst_addr_ok_c3", instAddrOk, 1'b1);
    finishRead("arb_inst", 4'd0, 32'h3333_4444, 1'b0);

    // Data write and inst read accepted together and completed together
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h1C00_0200; s.instSize = 2'd2;
    s.dataReq = 1'b1; s.dataWr = 1'b1; s.dataAddr = 32'h0000_0300; s.dataSize = 2'd2;
    s.dataWstrb = 4'hF; s.dataWdata = 32'h5566_7788;
    applyStimulus(s);
    checkBit("cc_inst_addr_ok", instAddrOk, 1'b1);
    checkBit("cc_data_addr_ok", dataAddrOk, 1'b1);
    s = '0;
    s.arready = 1'b1; s.awready = 1'b1; s.wready = 1'b1;
    applyStimulus(s);
    checkBit("cc_arvalid", arvalid, 1'b1);
    checkBit("cc_awvalid", awvalid, 1'b1);
    checkBit("cc_wvalid", wvalid, 1'b1);
    checkOutput("cc_awaddr", awaddr, 32'h0000_0300);
    checkOutput("cc_araddr", araddr, 32'h1C00_0200);
    s = '0;
    s.rvalid = 1'b1; s.rid = 4'd0; s.rdata = 32'h99AA_BBCC; s.bvalid = 1'b1;
    applyStimulus(s);
    checkBit("cc_inst_data_ok", instDataOk, 1'b1);
    checkBit("cc_data_data_ok", dataDataOk, 1'b1);
    checkOutput("cc_inst_rdata", instRdata, 32'h99AA_BBCC);

    // Inst read of a word with a pending data write
    s = '0;
    s.dataReq = 1'b1; s.dataWr = 1'b1; s.dataAddr = 32'h0000_0020; s.dataSize = 2'd2;
    s.dataWstrb = 4'hF; s.dataWdata = 32'h7777_0000;
    applyStimulus(s);
    checkBit("raw_wr_addr_ok", dataAddrOk, 1'b1);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h0000_0022; s.instSize = 2'd2;
    applyStimulus(s);
`ifdef BRIDGE_RAW_CHECK_EN
    checkBit("raw_inst_addr_ok_c1", instAddrOk, 1'b0);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h0000_0022; s.instSize = 2'd2;
    s.awready = 1'b1; s.wready = 1'b1;
    applyStimulus(s);
    checkBit("raw_inst_addr_ok_c2", instAddrOk, 1'b0);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h0000_0022; s.instSize = 2'd2; s.bvalid = 1'b1;
    applyStimulus(s);
    checkBit("raw_data_data_ok", dataDataOk, 1'b1);
    checkBit("raw_inst_addr_ok_c3", instAddrOk, 1'b0);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h0000_0022; s.instSize = 2'd2;
    applyStimulus(s);
    checkBit("raw_inst_addr_ok_c4", instAddrOk, 1'b1);
    finishRead("raw_inst", 4'd0, 32'h7777_0000, 1'b0);
`else
    checkBit("raw_inst_addr_ok_c1", instAddrOk, 1'b1);
    s = '0;
    s.awready = 1'b1; s.wready = 1'b1; s.arready = 1'b1;
    applyStimulus(s);
    checkBit("raw_arvalid", arvalid, 1'b1);
    checkOutput("raw_araddr", araddr, 32'h0000_0022);
    s = '0;
    s.bvalid = 1'b1; s.rvalid = 1'b1; s.rid = 4'd0; s.rdata = 32'h0BAD_0BAD;
    applyStimulus(s);
    checkBit("raw_data_data_ok", dataDataOk, 1'b1);
    checkBit("raw_inst_data_ok", instDataOk, 1'b1);
`endif

    // Data read behind an outstanding data write waits for the write's data_ok
    s = '0;
    s.dataReq = 1'b1; s.dataWr = 1'b1; s.dataAddr = 32'h0000_0040; s.dataSize = 2'd2;
    s.dataWstrb = 4'hF; s.dataWdata = 32'h4040_4040;
    applyStimulus(s);
    checkBit("rdw_wr_addr_ok", dataAddrOk, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      s = '0;
      s.dataReq = 1'b1; s.dataAddr = 32'h0000_0044; s.dataSize = 2'd2;
      s.awready = (c == 2); s.wready = (c == 2); s.bvalid = (c == 3);
      applyStimulus(s);
      checkBit($sformatf("rdw_data_addr_ok_c%0d", c), dataAddrOk, c == 4);
      if (c == 3) checkBit("rdw_wr_data_ok", dataDataOk, 1'b1);
    end
    finishRead("rdw_rd", 4'd1, 32'h0BAD_F00D, 1'b1);

    // Reset while a read waits in R_WAIT and a write is stuck in W_SEND
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h0000_0100; s.instSize = 2'd2;
    s.dataReq = 1'b1; s.dataWr = 1'b1; s.dataAddr = 32'h0000_0200; s.dataSize = 2'd2;
    s.dataWstrb = 4'hF; s.dataWdata = 32'h2020_2020;
    applyStimulus(s);
    checkBit("mr_inst_addr_ok", instAddrOk, 1'b1);
    s = '0;
    s.arready = 1'b1;
    applyStimulus(s);
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h0000_0300; s.instSize = 2'd2;
    applyStimulus(s);
    checkBit("mr_rready_before", rready, 1'b1);
    checkBit("mr_awvalid_before", awvalid, 1'b1);
    resetn = 1'b0;
    #1;
    checkBit("mr_rready", rready, 1'b0);
    checkBit("mr_arvalid", arvalid, 1'b0);
    checkBit("mr_awvalid", awvalid, 1'b0);
    checkBit("mr_wvalid", wvalid, 1'b0);
    checkBit("mr_bready", bready, 1'b0);
    checkBit("mr_inst_addr_ok", instAddrOk, 1'b0);
    s = '0;
    applyStimulus(s);
    resetn = 1'b1;
    s = '0;
    s.instReq = 1'b1; s.instAddr = 32'h1C00_0040; s.instSize = 2'd2;
    applyStimulus(s);
    checkBit("mr_next_addr_ok", instAddrOk, 1'b1);
    checkBit("mr_next_awvalid", awvalid, 1'b0);
    finishRead("mr_next", 4'd0, 32'h0123_4567, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
